// File: rtl/ldp_transport_ctrl.sv
// ldp_transport_ctrl: laser-disc transport FSM driving stream seeks and MPEG decoder register writes.
module ldp_transport_ctrl #(
    parameter int MAX_FRAME = 54000,
    parameter int SEARCH_TIMEOUT = 50000000,
    parameter logic [4:0] REG_CTRL_ADDR = 5'd0,
    parameter logic [4:0] REG_FLUSH_ADDR = 5'd1
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        play,
    input  logic        pause,
    input  logic        search_req,
    input  logic [19:0] search_target,
    input  logic        frame_tick,
    input  logic        mpeg_busy,
    input  logic        seek_ack,
    output logic        frame_search_req,
    output logic [31:0] frame_search,
    output logic [4:0]  reg_addr,
    output logic        reg_wr_en,
    output logic [31:0] reg_dta_in,
    output logic        is_playing,
    output logic        is_paused,
    output logic        is_searching,
    output logic        search_err,
    output logic [19:0] current_frame
);
    localparam int CW = $clog2(SEARCH_TIMEOUT + 1);
    localparam logic [31:0] MAXF = 32'(MAX_FRAME);
    localparam logic [CW-1:0] TMO = CW'(SEARCH_TIMEOUT - 1);
    typedef enum logic [2:0] {STOPPED, PLAYING, PAUSED, SEEK_ISSUE, SEEK_WAIT, FLUSH, WR_CTRL} state_t;
    state_t state, state_n, ret, ret_n;
    logic [31:0] pend, pend_n;
    logic [19:0] target, target_n, cur, cur_n;
    logic [CW-1:0] cnt, cnt_n;
    logic wr, err;
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state  <= STOPPED;
            ret    <= STOPPED;
            pend   <= '0;
            target <= '0;
            cur    <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_n;
            ret    <= ret_n;
            pend   <= pend_n;
            target <= target_n;
            cur    <= cur_n;
            cnt    <= cnt_n;
        end
    end
    always_comb begin
        state_n  = state;
        ret_n    = ret;
        pend_n   = pend;
        target_n = target;
        cur_n    = cur;
        cnt_n    = cnt;
        wr       = 1'b0;
        err      = 1'b0;
        case (state)
            STOPPED, PLAYING, PAUSED: begin
                if (state == PLAYING && frame_tick) begin
                    if (cur == MAXF[19:0]) begin
                        state_n = WR_CTRL;
                        pend_n  = 32'd0;
                        ret_n   = PAUSED;
                    end else cur_n = cur + 20'd1;
                end
                // one request per cycle: search_req > pause > play
                if (search_req) begin
                    if ({12'd0, search_target} <= MAXF) begin
                        target_n = search_target;
                        state_n  = SEEK_ISSUE;
                    end else err = 1'b1;
                end else if (pause && state == PLAYING) begin
                    state_n = WR_CTRL;
                    pend_n  = 32'd0;
                    ret_n   = PAUSED;
                end else if (play && state != PLAYING) begin
                    state_n = WR_CTRL;
                    pend_n  = 32'd1;
                    ret_n   = PLAYING;
                end
            end
            SEEK_ISSUE: begin
                state_n = SEEK_WAIT;
                cnt_n   = '0;
            end
            SEEK_WAIT: begin
                if (seek_ack) state_n = FLUSH;
                else if (cnt == TMO) begin
                    err     = 1'b1;
                    state_n = STOPPED;
                end else cnt_n = cnt + 1'b1;
            end
            FLUSH: begin
                wr = !mpeg_busy;
                if (!mpeg_busy) begin
                    cur_n   = target;
                    state_n = WR_CTRL;
                    pend_n  = 32'd0;
                    ret_n   = PAUSED;
                end
            end
            WR_CTRL: begin
                wr = !mpeg_busy;
                if (!mpeg_busy) state_n = ret;
            end
            default: state_n = STOPPED;
        endcase
    end
    assign reg_wr_en        = wr & ~rst;
    assign search_err       = err & ~rst;
    assign frame_search_req = state == SEEK_ISSUE;
    assign frame_search     = {12'd0, target};
    assign current_frame    = cur;
    assign is_playing       = state == PLAYING;
    assign is_paused        = state == PAUSED;
    assign is_searching     = state == SEEK_ISSUE || state == SEEK_WAIT || state == FLUSH;
    assign reg_addr         = state == FLUSH ? REG_FLUSH_ADDR : state == WR_CTRL ? REG_CTRL_ADDR : 5'd0;
    assign reg_dta_in       = state == FLUSH ? 32'd1 : state == WR_CTRL ? pend : 32'd0;
endmodule

// File: tb/tb_ldp_transport_ctrl.sv
// tb_ldp_transport_ctrl: directed and random checks of the transport controller against a transaction-level model.
module tb_ldp_transport_ctrl;
    localparam int MAXF = 54000;
    localparam int TO = 16;
    localparam int M_STOP = 0, M_PLAY = 1, M_PAUSE = 2, M_SREQ = 3, M_SWAIT = 4, M_WR = 5;
    logic sys_clk = 1'b0;
    logic rst, play, pause, search_req, frame_tick, mpeg_busy, seek_ack;
    logic [19:0] search_target;
    logic frame_search_req, reg_wr_en, is_playing, is_paused, is_searching, search_err;
    logic [31:0] frame_search, reg_dta_in;
    logic [4:0] reg_addr;
    logic [19:0] current_frame;
    int checks = 0, errors = 0;
    typedef struct {logic [4:0] a; logic [31:0] d; bit ld;} wr_t;
    wr_t wq[$];
    int mode, after, frame, tgt, wcnt;

    ldp_transport_ctrl #(.MAX_FRAME(MAXF), .SEARCH_TIMEOUT(TO), .REG_CTRL_ADDR(5'd0), .REG_FLUSH_ADDR(5'd1)) dut (
        .sys_clk(sys_clk), .rst(rst), .play(play), .pause(pause), .search_req(search_req),
        .search_target(search_target), .frame_tick(frame_tick), .mpeg_busy(mpeg_busy), .seek_ack(seek_ack),
        .frame_search_req(frame_search_req), .frame_search(frame_search), .reg_addr(reg_addr),
        .reg_wr_en(reg_wr_en), .reg_dta_in(reg_dta_in), .is_playing(is_playing), .is_paused(is_paused),
        .is_searching(is_searching), .search_err(search_err), .current_frame(current_frame)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mode = M_STOP; after = M_STOP; frame = 0; tgt = 0; wcnt = 0;
        wq.delete();
    endtask

    task automatic queue_ctrl(logic [31:0] d, int nxt);
        wq.delete();
        wq.push_back(wr_t'{5'd0, d, 1'b0});
        after = nxt;
        mode = M_WR;
    endtask

    task automatic cyc(bit r, bit pl, bit pa, bit sr, int st, bit tk, bit bz, bit ak);
        bit e_wr, e_err;
        int m0;
        rst = r; play = pl; pause = pa; search_req = sr; search_target = st[19:0];
        frame_tick = tk; mpeg_busy = bz; seek_ack = ak;
        @(negedge sys_clk);
        chk("is_playing", is_playing, mode == M_PLAY);
        chk("is_paused", is_paused, mode == M_PAUSE);
        chk("is_searching", is_searching, mode == M_SREQ || mode == M_SWAIT || (mode == M_WR && wq[0].ld));
        chk("current_frame", current_frame, frame);
        chk("frame_search", frame_search, tgt);
        chk("frame_search_req", frame_search_req, mode == M_SREQ);
        if (mode == M_WR) begin
            chk("reg_addr", reg_addr, wq[0].a);
            chk("reg_dta_in", reg_dta_in, wq[0].d);
        end
        e_wr = 0; e_err = 0; m0 = mode;
        case (m0)
            M_STOP, M_PLAY, M_PAUSE: begin
                if (m0 == M_PLAY && tk) begin
                    if (frame < MAXF) frame++;
                    else queue_ctrl(32'd0, M_PAUSE);
                end
                if (sr) begin
                    if (st <= MAXF) begin tgt = st; wq.delete(); mode = M_SREQ; end
                    else e_err = 1;
                end else if (pa && m0 == M_PLAY) queue_ctrl(32'd0, M_PAUSE);
                else if (pl && m0 != M_PLAY) queue_ctrl(32'd1, M_PLAY);
            end
            M_SREQ: begin mode = M_SWAIT; wcnt = 0; end
            M_SWAIT: begin
                wcnt++;
                if (ak) begin
                    wq.delete();
                    wq.push_back(wr_t'{5'd1, 32'd1, 1'b1});
                    wq.push_back(wr_t'{5'd0, 32'd0, 1'b0});
                    after = M_PAUSE;
                    mode = M_WR;
                end else if (wcnt == TO) begin e_err = 1; mode = M_STOP; end
            end
            default: begin
                if (!bz) begin
                    e_wr = 1;
                    if (wq[0].ld) frame = tgt;
                    void'(wq.pop_front());
                    if (wq.size() == 0) mode = after;
                end
            end
        endcase
        if (r) begin e_wr = 0; e_err = 0; model_reset(); end
        chk("reg_wr_en", reg_wr_en, e_wr);
        chk("search_err", search_err, e_err);
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic reset_outputs_zero();
        chk("rst_status", {is_playing, is_paused, is_searching}, 0);
        chk("rst_pulses", {reg_wr_en, frame_search_req, search_err}, 0);
        chk("rst_frame", current_frame, 0);
        chk("rst_fsearch", frame_search, 0);
        chk("rst_addr", reg_addr, 0);
        chk("rst_data", reg_dta_in, 0);
    endtask

    initial begin
        rst = 1; play = 0; pause = 0; search_req = 0; search_target = '0;
        frame_tick = 0; mpeg_busy = 0; seek_ack = 0;
        model_reset();
        @(posedge sys_clk);
        #1;
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        reset_outputs_zero();
        idle();
        // play from STOPPED: one write then PLAYING two cycles after play
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        chk("play_wr_en", reg_wr_en, 1);
        chk("play_addr", reg_addr, 0);
        chk("play_data", reg_dta_in, 1);
        idle();
        chk("play_state", is_playing, 1);
        repeat (5) cyc(0, 0, 0, 0, 0, 1, 0, 0);
        chk("five_ticks", current_frame, 5);
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("busy_no_wr", reg_wr_en, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("pause_state", is_paused, 1);
        // search 1234 while playing
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        idle();
        chk("resume", is_playing, 1);
        cyc(0, 0, 0, 1, 1234, 0, 0, 0);
        chk("seek_req", frame_search_req, 1);
        chk("seek_target", frame_search, 1234);
        idle();
        repeat (10) idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("flush_addr", reg_addr, 1);
        chk("flush_data", reg_dta_in, 1);
        idle();
        chk("ctrl_addr", reg_addr, 0);
        chk("ctrl_data", reg_dta_in, 0);
        idle();
        chk("search_paused", is_paused, 1);
        chk("search_frame", current_frame, 1234);
        // out-of-range target
        cyc(0, 0, 0, 1, 60000, 0, 0, 0);
        chk("bad_err", search_err, 1);
        chk("bad_no_seek", frame_search_req, 0);
        chk("bad_state", is_paused, 1);
        idle();
        chk("bad_err_one_cycle", search_err, 0);
        chk("bad_frame", current_frame, 1234);
        // timeout after 16 cycles of SEEK_WAIT
        cyc(0, 0, 0, 1, 100, 0, 0, 0);
        idle();
        repeat (15) idle();
        chk("to_still_wait", is_searching, 1);
        idle();
        chk("to_stopped", {is_playing, is_paused, is_searching}, 0);
        chk("to_frame", current_frame, 1234);
        // simultaneous requests in PAUSED: search wins
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        idle();
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        idle();
        chk("pri_paused", is_paused, 1);
        cyc(0, 1, 1, 1, 500, 0, 0, 0);
        chk("pri_search", {is_playing, is_paused, is_searching}, 3'b001);
        chk("pri_target", frame_search, 500);
        idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        idle();
        chk("pri_frame", current_frame, 500);
        // reset in SEEK_WAIT
        cyc(0, 0, 0, 1, 777, 0, 0, 0);
        idle();
        repeat (3) idle();
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        reset_outputs_zero();
        idle();
        // end of disc: auto-pause holding MAX_FRAME
        cyc(0, 0, 0, 1, 53998, 0, 0, 0);
        idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        idle();
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        idle();
        chk("eod_playing", is_playing, 1);
        repeat (2) cyc(0, 0, 0, 0, 0, 1, 0, 0);
        chk("eod_frame_max", current_frame, 54000);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        chk("eod_hold", current_frame, 54000);
        chk("eod_leaving_play", is_playing, 0);
        idle();
        chk("eod_paused", is_paused, 1);
        chk("eod_frame", current_frame, 54000);
        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int st;
            st = ($urandom_range(0, 9) == 0) ? int'($urandom_range(54001, 1048575)) : int'($urandom_range(0, 54000));
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 29) == 0, st, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 7) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
